mem_access_unit: RTL and testbench

// - Load/store front end between the MIPS datapath and the word-wide data memory
//   (combinational read, write on posedge clk).
// - Turns byte/half/word loads and stores into aligned word accesses:

---
 rtl/mau_pkg.sv | 32 +++
 rtl/mem_access_unit_if.sv | 38 +++
 rtl/byte_lane_mux.sv | 45 ++++
 rtl/mem_access_unit.sv | 97 +++++++++
 tb/tb_mem_access_unit.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mau_pkg.sv
// Shared constants, state encoding and request checker for mem_access_unit.
// Imported by the load/store unit, its lane mux and the bench.
package mau_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  localparam int unsigned MEM_BYTES_DEF = 65536;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_t;

  function automatic logic req_err(
    input logic [1:0]  size,
    input logic [31:0] addr,
    input int unsigned mem_bytes
  );
    logic oor;
    oor = {1'b0, addr} >= 33'(mem_bytes);
    return (size == SIZE_ILLEGAL) ||
           ((size == SIZE_HALF) && addr[0]) ||
           ((size == SIZE_WORD) && (addr[1:0] != 2'b00)) ||
           oor;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bundle of mem_access_unit.
// slave: unit side; master: datapath plus memory side.
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/byte_lane_mux.sv
// Load lane extract/extend and sub-word store merge.
// Ports: i_size/i_off/i_signed select, i_rdata/i_old/i_wdata data, o_load/o_merge.
module byte_lane_mux
  import mau_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_signed,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [4:0]  w_bpos;
  logic [4:0]  w_hpos;
  logic [7:0]  w_b;
  logic [15:0] w_h;

  assign w_bpos = {i_off, 3'b000};
  assign w_hpos = {i_off[1], 4'b0000};
  assign w_b    = i_rdata[w_bpos +: 8];
  assign w_h    = i_rdata[w_hpos +: 16];

  always_comb begin
    o_load  = i_rdata;
    o_merge = i_old;
    unique case (1'b1)
      (i_size == SIZE_BYTE): begin
        o_load = {{24{i_signed & w_b[7]}}, w_b};
        o_merge[w_bpos +: 8] = i_wdata[7:0];
      end
      (i_size == SIZE_HALF): begin
        o_load = {{16{i_signed & w_h[15]}}, w_h};
        o_merge[w_hpos +: 16] = i_wdata[15:0];
      end
      default: begin
        o_load  = i_rdata;
        o_merge = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: byte/half/word requests to aligned word accesses.
// Ports: clk, rst_n, bus (slave: req_*, resp_*, mem_*).
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.slave  bus
);

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_req_err;
  logic        w_sub;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign bus.req_ready = (r_state == IDLE);
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_req_err     = req_err(bus.req_size, bus.req_addr, MEM_BYTES);
  // only legal requests reach ACCESS, so non-word means byte/half
  assign w_sub         = (r_size != SIZE_WORD);

  byte_lane_mux u_lane (
    .i_size   (r_size),
    .i_off    (r_addr[1:0]),
    .i_signed (r_signed),
    .i_rdata  (bus.mem_rdata),
    .i_old    (r_word),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (w_accept) w_next = w_req_err ? RESP : ACCESS;
      ACCESS: w_next = (r_write && w_sub) ? WRITE : RESP;
      WRITE:  w_next = RESP;
      RESP:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= SIZE_BYTE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_word   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= bus.req_write;
        r_signed <= bus.req_signed;
        r_size   <= bus.req_size;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        r_err    <= w_req_err;
        r_rdata  <= '0;
      end
      if (r_state == ACCESS) begin
        if (!r_write)  r_rdata <= w_load;
        else if (w_sub) r_word <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr   = {r_addr[31:2], 2'b00};
  assign bus.mem_we     = ((r_state == ACCESS) && r_write && !w_sub) ||
                          (r_state == WRITE);
  assign bus.mem_wdata  = (r_state == WRITE) ? w_merge : r_wdata;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = bus.resp_valid ? r_rdata : 32'h0;
  assign bus.resp_err   = bus.resp_valid & r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit against a byte-array memory model.
// Directed cases, reset abort and randomized requests.
module tb_mem_access_unit;
  import mau_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_BYTES(65536)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:16383];
  logic [7:0]  ref_mem [0:65535];

  assign bus.mem_rdata = mem[bus.mem_addr[15:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[15:2]] <= bus.mem_wdata;

  int cyc = 0;
  int we_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst_n && bus.mem_we) we_cnt <= we_cnt + 1;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor
  initial begin
    exp_t me;
    int we_seen;
    we_seen = 0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.resp_valid) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected none");
        end else begin
          me = sbq.pop_front();
          chk("resp_rdata", bus.resp_rdata, me.rdata);
          chk("resp_err", 32'(bus.resp_err), 32'(me.err));
          chk("latency", 32'(cyc - me.acc + 1), 32'(me.lat));
          chk("mem_we_count", 32'(we_cnt - we_seen), 32'(me.we));
          we_seen = we_cnt;
        end
      end
    end
  end

  task automatic idle_bus();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic issue(bit w, bit [1:0] sz, bit sg,
                       logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int nb;
    int n;
    logic [31:0] v;
    logic [31:0] mask;
    nb = 1 << sz;
    e.err = (sz == 2'd3) || (a >= 32'h10000) ||
            (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    e.rdata = 32'h0;
    e.we = 0;
    if (e.err) begin
      e.lat = 1;
    end else if (!w) begin
      v = 32'h0;
      for (int i = 0; i < nb; i++)
        v |= 32'(ref_mem[16'(a + 32'(i))]) << (8 * i);
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      if (sg && v[8 * nb - 1]) v |= ~mask;
      e.rdata = v;
      e.lat = 2;
    end else begin
      for (int i = 0; i < nb; i++)
        ref_mem[16'(a + 32'(i))] = wd[8 * i +: 8];
      e.we = 1;
      e.lat = (sz == 2'd2) ? 2 : 3;
    end
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.acc = cyc;
    sbq.push_back(e);
    chk("ready_low_after_accept", 32'(bus.req_ready), 32'h0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'h0);
  endtask

  task automatic set_word(int idx, logic [31:0] v);
    mem[idx] = v;
    for (int k = 0; k < 4; k++) ref_mem[idx * 4 + k] = v[8 * k +: 8];
  endtask

  initial begin
    logic [31:0] a;
    bit [1:0] sz;
    int r;
    logic [31:0] mw;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    for (int i = 0; i < 16384; i++) set_word(i, 32'h0);
    for (int i = 0; i < 64; i++) set_word(i, $urandom);
    set_word(16383, $urandom);
    set_word(3, 32'h8899AABB);

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
    rst_n = 1'b1;

    issue(0, 2'd0, 1, 32'h0D, 32'h0); idle_bus();
    issue(0, 2'd0, 0, 32'h0D, 32'h0); idle_bus();
    issue(1, 2'd0, 0, 32'h0E, 32'hFFFF_FF11); idle_bus();
    drain();
    chk("mem_word_0C", mem[3], 32'h8811AABB);
    issue(0, 2'd2, 0, 32'h0C, 32'h0); idle_bus();
    issue(1, 2'd1, 0, 32'h0F, 32'h1234); idle_bus();
    issue(0, 2'd3, 0, 32'h0C, 32'h0); idle_bus();
    issue(0, 2'd2, 0, 32'h10000, 32'h0); idle_bus();
    drain();

    issue(1, 2'd2, 0, 32'h0, 32'hA5A5_0001);
    issue(1, 2'd2, 0, 32'h4, 32'h5A5A_0002);
    issue(1, 2'd2, 0, 32'h8, 32'hC3C3_0003);
    idle_bus();
    drain();
    chk("b2b_word0", mem[0], 32'hA5A5_0001);
    chk("b2b_word1", mem[1], 32'h5A5A_0002);
    chk("b2b_word2", mem[2], 32'hC3C3_0003);

    issue(0, 2'd2, 0, 32'hFFFC, 32'h0); idle_bus();
    issue(0, 2'd1, 1, 32'hFFFE, 32'h0); idle_bus();
    issue(0, 2'd0, 0, 32'hFFFF, 32'h0); idle_bus();
    issue(0, 2'd1, 0, 32'hFFFF, 32'h0); idle_bus();
    drain();

    // reset during WRITE of a byte store
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0C;
    bus.req_wdata  = 32'h55;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_we_in_write", 32'(bus.mem_we), 32'h1);
    chk("abort_wdata", bus.mem_wdata, 32'h8811AA55);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_async", 32'(bus.mem_we), 32'h0);
    chk("abort_ready_in_rst", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_word_kept", mem[3], 32'h8811AABB);
    chk("abort_ready_after", 32'(bus.req_ready), 32'h1);
    chk("abort_no_resp", 32'(bus.resp_valid), 32'h0);

    repeat (300) begin
      r = $urandom_range(0, 15);
      sz = (r == 0) ? 2'd3 : 2'(r % 3);
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom | 32'h10000;
      else if (r == 1) a = 32'hFFFC + 32'($urandom_range(0, 3));
      else             a = 32'($urandom_range(0, 255));
      if (sz != 2'd3 && $urandom_range(0, 1) == 1)
        a = a & ~((32'd1 << sz) - 32'd1);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            a, $urandom);
      if ($urandom_range(0, 1) == 1) idle_bus();
    end
    idle_bus();
    drain();

    for (int i = 0; i < 64; i++) begin
      mw = {ref_mem[i*4+3], ref_mem[i*4+2], ref_mem[i*4+1], ref_mem[i*4]};
      chk("final_mem", mem[i], mw);
    end
    mw = {ref_mem[65535], ref_mem[65534], ref_mem[65533], ref_mem[65532]};
    chk("final_mem_top", mem[16383], mw);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
